nfc_input_stream_packer: RTL and testbench

//  Parametrised successor of the NAND data-in buffering path. Takes DDR-captured DQ bytes (rise/fall per

---
 rtl/nfc_input_pkg.sv | 19 +
 rtl/nfc_sync_fifo.sv | 78 +++++++
 rtl/nfc_input_stream_packer.sv | 223 ++++++++++++++++++++++
 tb/tb_nfc_input_stream_packer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nfc_input_pkg.sv
// Shared types and helpers for the NAND data-in stream packer.
package nfc_input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  function automatic int out_bytes(input int dq_bytes, input int pack);
    return 2 * dq_bytes * pack;
  endfunction

  // Keep-mask bit: byte idx is enabled when fewer than n bytes precede it.
  function automatic logic byte_kept(input int idx, input logic [15:0] n);
    return (16'(idx) < n);
  endfunction

endpackage

// File: rtl/nfc_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output stage.
// The output register counts toward the level, so total capacity is 2**AW words.
module nfc_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int AW    = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [AW:0]      level_o,
  output logic             drop_o
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      mem_cnt_q;
  logic [AW:0]      level_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic full_s;
  logic pop_s;
  logic push_s;
  logic load_s;

  assign full_s = (level_q == FULL_LEVEL);
  assign pop_s  = out_valid_q & rd_ready_i;
  assign push_s = wr_en_i & (~full_s | pop_s);
  assign load_s = (mem_cnt_q != '0) & (~out_valid_q | pop_s);
  assign drop_o = wr_en_i & full_s & ~pop_s;

  // Storage array write port; contents are don't-care until pointers cover them.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers, occupancy and the output register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (load_s) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        out_data_q  <= mem_q[rd_ptr_q];
        out_valid_q <= 1'b1;
      end else if (pop_s) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end
      mem_cnt_q <= mem_cnt_q + (AW + 1)'(push_s) - (AW + 1)'(load_s);
      level_q   <= level_q + (AW + 1)'(push_s) - (AW + 1)'(pop_s);
    end
  end

  assign rd_valid_o = out_valid_q;
  assign rd_data_o  = out_data_q;
  assign level_o    = level_q;

endmodule

// File: rtl/nfc_input_stream_packer.sv
// Qualifies DDR-captured DQ beats through a capture-latency delay line, packs them into
// stream words with byte keep and length-driven last, and buffers them in a sync FIFO.
module nfc_input_stream_packer
  import nfc_input_pkg::*;
#(
  parameter int DQ_BYTES        = 1,
  parameter int PACK            = 2,
  parameter int FIFO_AW         = 9,
  parameter int CAPTURE_LATENCY = 5
) (
  input  logic                          iSystemClock,
  input  logic                          iModuleResetN,
  input  logic                          iCmdStart,
  input  logic [15:0]                   iCmdLength,
  output logic                          oCmdReady,
  input  logic                          iAbort,
  input  logic                          iCaptureEnable,
  input  logic [8*DQ_BYTES-1:0]         iDQRise,
  input  logic [8*DQ_BYTES-1:0]         iDQFall,
  output logic                          oStreamValid,
  input  logic                          iStreamReady,
  output logic [16*DQ_BYTES*PACK-1:0]   oStreamData,
  output logic [2*DQ_BYTES*PACK-1:0]    oStreamKeep,
  output logic                          oStreamLast,
  output logic                          oOverflow,
  output logic                          oBusy,
  output logic [FIFO_AW:0]              oLevel
);

  localparam int BEAT_BYTES = 2 * DQ_BYTES;
  localparam int OUT_BYTES  = out_bytes(DQ_BYTES, PACK);
  localparam int BEAT_BITS  = 8 * BEAT_BYTES;
  localparam int OUT_BITS   = 8 * OUT_BYTES;
  localparam int IDX_W      = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int FIFO_W     = 1 + OUT_BYTES + OUT_BITS;
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(PACK - 1);
  localparam logic [15:0]      BEAT_BYTES_L = 16'(BEAT_BYTES);

  state_t                     state_q, state_d;
  logic [15:0]                cnt_q, cnt_d;
  logic [CAPTURE_LATENCY-1:0] dl_q, dl_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [OUT_BITS-1:0]        pdata_q, pdata_d;
  logic [OUT_BYTES-1:0]       pkeep_q, pkeep_d;
  logic                       push_q, push_d;
  logic [FIFO_W-1:0]          push_word_q, push_word_d;
  logic                       ovf_q, ovf_d;

  logic [BEAT_BITS-1:0]  beat_s;
  logic [BEAT_BITS-1:0]  beat_m_s;
  logic [BEAT_BYTES-1:0] beat_keep_s;
  logic [OUT_BITS-1:0]   data_ext_s;
  logic [OUT_BYTES-1:0]  keep_ext_s;
  logic [OUT_BITS-1:0]   word_data_s;
  logic [OUT_BYTES-1:0]  word_keep_s;
  logic [15:0]           take_s;
  logic [15:0]           cnt_left_s;
  logic                  beat_v_s;
  logic                  word_done_s;
  logic                  drain_exit_s;

  logic                  fifo_valid_s;
  logic [FIFO_W-1:0]     fifo_data_s;
  logic                  fifo_drop_s;

  assign beat_v_s     = dl_q[CAPTURE_LATENCY-1] & (state_q == ST_CAPTURE) & (cnt_q != 16'd0);
  assign word_done_s  = beat_v_s & ((idx_q == IDX_LAST) | (cnt_left_s == 16'd0));
  // A dropped final word would otherwise leave DRAIN waiting forever for its handshake.
  assign drain_exit_s = (fifo_valid_s & iStreamReady & fifo_data_s[FIFO_W-1]) |
                        (fifo_drop_s & push_q & push_word_q[FIFO_W-1]);

  // Mask the incoming beat to the remaining length and place it at its slot.
  always_comb begin
    beat_s      = {iDQFall, iDQRise};
    take_s      = (cnt_q < BEAT_BYTES_L) ? cnt_q : BEAT_BYTES_L;
    cnt_left_s  = cnt_q - take_s;
    beat_m_s    = '0;
    beat_keep_s = '0;
    for (int b = 0; b < BEAT_BYTES; b++) begin
      beat_keep_s[b] = byte_kept(b, take_s);
      if (beat_keep_s[b]) begin
        beat_m_s[8*b +: 8] = beat_s[8*b +: 8];
      end else begin
        beat_m_s[8*b +: 8] = 8'h00;
      end
    end
    data_ext_s                  = '0;
    data_ext_s[BEAT_BITS-1:0]   = beat_m_s;
    keep_ext_s                  = '0;
    keep_ext_s[BEAT_BYTES-1:0]  = beat_keep_s;
    word_data_s = pdata_q | (data_ext_s << (int'(idx_q) * BEAT_BITS));
    word_keep_s = pkeep_q | (keep_ext_s << (int'(idx_q) * BEAT_BYTES));
  end

  // Transfer FSM, byte counter, delay line and pack register next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pdata_d     = pdata_q;
    pkeep_d     = pkeep_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    dl_d[0]     = iCaptureEnable & (state_q == ST_CAPTURE);
    for (int i = 1; i < CAPTURE_LATENCY; i++) begin
      dl_d[i] = dl_q[i-1];
    end
    if (fifo_drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (iCmdStart && (iCmdLength != 16'd0)) begin
          state_d = ST_CAPTURE;
          cnt_d   = iCmdLength;
          ovf_d   = 1'b0;
          idx_d   = '0;
          pdata_d = '0;
          pkeep_d = '0;
          dl_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (beat_v_s) begin
          cnt_d = cnt_left_s;
          if (word_done_s) begin
            push_d      = 1'b1;
            push_word_d = {(cnt_left_s == 16'd0), word_keep_s, word_data_s};
            idx_d       = '0;
            pdata_d     = '0;
            pkeep_d     = '0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            pdata_d = word_data_s;
            pkeep_d = word_keep_s;
          end
          if (cnt_left_s == 16'd0) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (drain_exit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; abort flushes everything except the sticky overflow flag.
  always_ff @(posedge iSystemClock) begin
    if (!iModuleResetN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      dl_q        <= '0;
      idx_q       <= '0;
      pdata_q     <= '0;
      pkeep_q     <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      ovf_q       <= 1'b0;
    end else if (iAbort) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      dl_q        <= '0;
      idx_q       <= '0;
      pdata_q     <= '0;
      pkeep_q     <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      ovf_q       <= ovf_q;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dl_q        <= dl_d;
      idx_q       <= idx_d;
      pdata_q     <= pdata_d;
      pkeep_q     <= pkeep_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      ovf_q       <= ovf_d;
    end
  end

  nfc_sync_fifo #(
    .WIDTH (FIFO_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk_i      (iSystemClock),
    .rst_ni     (iModuleResetN),
    .flush_i    (iAbort),
    .wr_en_i    (push_q),
    .wr_data_i  (push_word_q),
    .rd_ready_i (iStreamReady),
    .rd_valid_o (fifo_valid_s),
    .rd_data_o  (fifo_data_s),
    .level_o    (oLevel),
    .drop_o     (fifo_drop_s)
  );

  assign oStreamValid = fifo_valid_s;
  assign oStreamLast  = fifo_data_s[FIFO_W-1];
  assign oStreamKeep  = fifo_data_s[OUT_BITS +: OUT_BYTES];
  assign oStreamData  = fifo_data_s[OUT_BITS-1:0];
  assign oOverflow    = ovf_q;
  assign oCmdReady    = (state_q == ST_IDLE);
  assign oBusy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nfc_input_stream_packer.sv
// Self-checking bench: table-driven transfers, overflow/abort/reset sequences and a randomized run.
module tb_nfc_input_stream_packer;

  localparam int DQ_BYTES = 1;
  localparam int PACK     = 2;
  localparam int FIFO_AW  = 9;
  localparam int LAT      = 5;
  localparam int OB       = 2 * DQ_BYTES * PACK;

  logic        clk;
  logic        rst_n;
  logic        cmd_start;
  logic [15:0] cmd_len;
  logic        cmd_ready;
  logic        abort;
  logic        cap_en;
  logic [7:0]  dq_rise;
  logic [7:0]  dq_fall;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_last;
  logic        ovf;
  logic        busy;
  logic [9:0]  level;

  nfc_input_stream_packer #(
    .DQ_BYTES(DQ_BYTES), .PACK(PACK), .FIFO_AW(FIFO_AW), .CAPTURE_LATENCY(LAT)
  ) dut (
    .iSystemClock(clk), .iModuleResetN(rst_n), .iCmdStart(cmd_start), .iCmdLength(cmd_len),
    .oCmdReady(cmd_ready), .iAbort(abort), .iCaptureEnable(cap_en), .iDQRise(dq_rise),
    .iDQFall(dq_fall), .oStreamValid(s_valid), .iStreamReady(s_ready), .oStreamData(s_data),
    .oStreamKeep(s_keep), .oStreamLast(s_last), .oOverflow(ovf), .oBusy(busy), .oLevel(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } word_t;
  typedef struct { int len; int nbeats; int nwords; logic [31:0] ldata; logic [3:0] lkeep; } vec_t;

  word_t      exp_q[$];
  logic [7:0] beat_bytes[$];
  vec_t       vecs[7];
  word_t      prev_w;
  word_t      last_pop;
  bit         prev_hold;
  bit         rand_ready;
  int         checks;
  int         errors;
  int         popped;
  int         lasts;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: chop the first len received bytes into OB-byte words.
  task automatic build_expected(input int len);
    int    n;
    int    cnt;
    word_t w;
    n = (len < beat_bytes.size()) ? len : beat_bytes.size();
    exp_q.delete();
    for (int base = 0; base < n; base += OB) begin
      cnt    = (n - base < OB) ? n - base : OB;
      w.data = '0;
      for (int j = 0; j < cnt; j++) w.data[8*j +: 8] = beat_bytes[base + j];
      w.keep = 4'((1 << cnt) - 1);
      w.last = (base + OB >= n) && (n == len);
      exp_q.push_back(w);
    end
  endtask

  task automatic step();
    word_t e;
    if (prev_hold)
      check("stall_stable", {31'd0, s_valid, s_last, s_keep, s_data},
            {31'd0, 1'b1, prev_w.last, prev_w.keep, prev_w.data});
    if (s_valid && s_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got 0x%0h expected none", s_data);
      end else begin
        e = exp_q.pop_front();
        check("word", {27'd0, s_last, s_keep, s_data}, {27'd0, e.last, e.keep, e.data});
      end
      popped++;
      if (s_last) lasts++;
      last_pop = '{s_data, s_keep, s_last};
    end
    prev_hold = s_valid && !s_ready;
    prev_w    = '{s_data, s_keep, s_last};
    @(posedge clk); #1;
    if (rand_ready) s_ready = 1'($urandom_range(0, 1));
  endtask

  // Beat k: enable in cycle k, its data CAPTURE_LATENCY cycles later.
  task automatic send_beats(input int nbeats);
    for (int c = 0; c < nbeats + LAT; c++) begin
      cap_en = (c < nbeats);
      if (c >= LAT) begin
        dq_rise = beat_bytes[2*(c-LAT)];
        dq_fall = beat_bytes[2*(c-LAT)+1];
      end else begin
        dq_rise = 8'($urandom);
        dq_fall = 8'($urandom);
      end
      step();
    end
    cap_en = 1'b0;
  endtask

  task automatic run_transfer(input int len, input int nbeats);
    cmd_start = 1'b1;
    cmd_len   = 16'(len);
    step();
    cmd_start = 1'b0;
    cmd_len   = 16'd0;
    send_beats(nbeats);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin step(); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    checks = 0; errors = 0; popped = 0; lasts = 0;
    prev_hold = 0; rand_ready = 0;
    rst_n = 1'b0; cmd_start = 1'b0; cmd_len = 16'd0; abort = 1'b0;
    cap_en = 1'b0; dq_rise = 8'd0; dq_fall = 8'd0; s_ready = 1'b1;

    vecs[0] = '{8, 4, 2, 32'h08070605, 4'hF};
    vecs[1] = '{5, 4, 2, 32'h00000005, 4'h1};
    vecs[2] = '{1, 1, 1, 32'h00000001, 4'h1};
    vecs[3] = '{4, 2, 1, 32'h04030201, 4'hF};
    vecs[4] = '{7, 4, 2, 32'h00070605, 4'h7};
    vecs[5] = '{3, 3, 1, 32'h00030201, 4'h7};
    vecs[6] = '{6, 3, 2, 32'h00000605, 4'h3};

    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("reset_outputs", {52'd0, s_valid, s_last, s_keep, ovf, busy, cmd_ready},
          {52'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1});
    check("reset_data", 64'(s_data), 64'd0);
    check("reset_level", 64'(level), 64'd0);

    // Table-driven transfers with consumer always ready.
    for (int v = 0; v < 7; v++) begin
      beat_bytes.delete();
      for (int k = 0; k < 2 * vecs[v].nbeats; k++) beat_bytes.push_back(8'(k + 1));
      build_expected(vecs[v].len);
      popped = 0; lasts = 0;
      run_transfer(vecs[v].len, vecs[v].nbeats);
      wait_idle(100);
      check("n_words", 64'(popped), 64'(vecs[v].nwords));
      check("final_word", {27'd0, last_pop.last, last_pop.keep, last_pop.data},
            {27'd0, 1'b1, vecs[v].lkeep, vecs[v].ldata});
    end

    // FIFO full: 513 words with no consumer, the last one is lost.
    s_ready = 1'b0;
    beat_bytes.delete();
    for (int k = 0; k < 2052; k++) beat_bytes.push_back(8'($urandom));
    build_expected(2052);
    void'(exp_q.pop_back());
    popped = 0;
    run_transfer(2052, 1026);
    repeat (4) step();
    check("full_level", 64'(level), 64'd512);
    check("overflow_set", 64'(ovf), 64'd1);
    s_ready = 1'b1;
    for (int n = 0; n < 700 && exp_q.size() > 0; n++) step();
    check("full_drained", 64'(popped), 64'd512);
    check("full_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) step();
    check("full_level_zero", 64'(level), 64'd0);

    // Abort mid-CAPTURE with three words queued.
    s_ready = 1'b0;
    beat_bytes.delete();
    for (int k = 0; k < 12; k++) beat_bytes.push_back(8'(k + 16));
    build_expected(100);
    run_transfer(100, 6);
    repeat (3) step();
    check("abort_pre_level", 64'(level), 64'd3);
    check("abort_pre_ovf_clear", 64'(ovf), 64'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    prev_hold = 0;
    exp_q.delete();
    check("abort_outputs", {61'd0, s_valid, cmd_ready, busy}, {61'd0, 1'b0, 1'b1, 1'b0});
    check("abort_level", 64'(level), 64'd0);
    s_ready = 1'b1;

    // Random backpressure on a long transfer.
    rand_ready = 1;
    beat_bytes.delete();
    for (int k = 0; k < 1000; k++) beat_bytes.push_back(8'($urandom));
    build_expected(1000);
    popped = 0; lasts = 0;
    run_transfer(1000, 500);
    wait_idle(3000);
    rand_ready = 0;
    s_ready = 1'b1;
    check("rand_words", 64'(popped), 64'd250);
    check("rand_single_last", 64'(lasts), 64'd1);

    // Reset during DRAIN, then a zero-length start.
    s_ready = 1'b0;
    beat_bytes.delete();
    for (int k = 0; k < 8; k++) beat_bytes.push_back(8'(k + 1));
    build_expected(8);
    run_transfer(8, 4);
    repeat (3) step();
    check("drain_busy_level", {54'd0, busy, level}, {54'd0, 1'b1, 10'd2});
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    prev_hold = 0;
    exp_q.delete();
    check("reset_drain_outputs", {52'd0, s_valid, s_last, s_keep, ovf, busy, cmd_ready},
          {52'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1});
    check("reset_drain_level", 64'(level), 64'd0);
    check("reset_drain_data", 64'(s_data), 64'd0);
    cmd_start = 1'b1;
    cmd_len   = 16'd0;
    step();
    cmd_start = 1'b0;
    step();
    check("len0_ignored", {62'd0, cmd_ready, busy}, {62'd0, 1'b1, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
